// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and a constant-evaluable ceil(log2) helper also used by the pulse generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    localparam int unsigned C_DATA_BITS  = 8;
    localparam int unsigned C_OVERSAMPLE = 16;

    // Never returns 0 so it can size a counter directly.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input with a
// configurable reset value (idle level of the line it guards).
module sync_2ff #(
    parameter logic P_RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= P_RESET_VAL;
            sync_q <= P_RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deframes start / LSB-first data / one stop bit using the
// x16 oversampling strobe, with single-cycle data_valid and frame_error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned P_DATA_BITS  = C_DATA_BITS,
    parameter int unsigned P_OVERSAMPLE = C_OVERSAMPLE
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   tick_x16,
    input  logic                   rx,
    output logic [P_DATA_BITS-1:0] data,
    output logic                   data_valid,
    output logic                   frame_error,
    output logic                   busy
);

    localparam int unsigned TW = clog2(P_OVERSAMPLE);
    localparam int unsigned BW = clog2(P_DATA_BITS);
    localparam logic [TW-1:0] TICK_HALF = TW'(P_OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(P_OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(P_DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    logic rx_s;

    uart_state_e            state_q, state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [P_DATA_BITS-1:0] shift_q, shift_d;
    logic [P_DATA_BITS-1:0] data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   frame_error_q, frame_error_d;
    logic                   busy_q, busy_d;

    sync_2ff #(.P_RESET_VAL(1'b1)) u_rx_sync (
        .clk (CLK),
        .rst (RST),
        .d   (rx),
        .q   (rx_s)
    );

    // Only IDLE->START entry ignores the tick; everything else waits for it.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_x16 && (tick_cnt_q == TICK_HALF)) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end else if (tick_x16) begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_DATA: begin
                if (tick_x16 && (tick_cnt_q == TICK_LAST)) begin
                    shift_d    = {rx_s, shift_q[P_DATA_BITS-1:1]};
                    tick_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + BIT_ONE;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (tick_x16) begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_STOP: begin
                if (tick_x16 && (tick_cnt_q == TICK_LAST)) begin
                    tick_cnt_d = '0;
                    if (rx_s) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = ST_BREAK;
                    end
                end else if (tick_x16) begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_BREAK: begin
                // Hold off until the line recovers so a stuck-low line cannot retrigger.
                if (tick_x16 && rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule
